// File: rtl/rv_pipe_pkg.sv
// Shared definitions for the ready/valid pipeline buffers.
// SKID_* : occupancy state encoding {skid_v, main_v}
// CNT_W  : width of the occupancy count output
package rv_pipe_pkg;

  localparam logic [1:0] SKID_EMPTY = 2'b00;
  localparam logic [1:0] SKID_ONE   = 2'b01;
  localparam logic [1:0] SKID_FULL  = 2'b11;

  localparam int CNT_W = 2;

endpackage

// File: rtl/rvdffe_sync.sv
// Enabled register with synchronous active-high clear.
// clk : rising-edge clock
// clr : synchronous clear, wins over en
// en  : load enable
// d   : next value
// q   : registered value
module rvdffe_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/rvskid_buf.sv
// Two-entry skid buffer feeding a plain output register.
// Breaks the ready path between producer and consumer at full throughput.
// clk       : clock, all state on rising edge
// rst       : synchronous active-high reset, clears all state and data
// flush     : synchronous kill of held entries
// in_valid  : producer offers in_data
// in_ready  : buffer accepts this cycle (flop-driven)
// in_data   : producer payload
// out_valid : out_data holds a valid entry
// out_ready : consumer accepts out_data
// out_data  : head entry, straight from the main register
// count     : occupancy 0..2
module rvskid_buf
  import rv_pipe_pkg::*;
#(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count
);

  logic             main_v;
  logic             skid_v;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic [1:0]       state;

  logic             push;
  logic             pop;
  logic             main_ld;
  logic             skid_ld;
  logic             main_v_d;
  logic             skid_v_d;
  logic [WIDTH-1:0] main_d;

  assign state = {skid_v, main_v};

  // Ready depends only on the skid flag, so there is no combinational
  // path from out_ready or in_valid.
  assign in_ready  = ~skid_v;
  assign push      = in_valid & in_ready;
  assign pop       = main_v & out_ready;

  assign out_valid = main_v;
  assign out_data  = main_q;
  assign count     = {1'b0, main_v} + {1'b0, skid_v};

  // Next-state and load decode
  always_comb begin
    main_ld  = 1'b0;
    skid_ld  = 1'b0;
    main_v_d = main_v;
    skid_v_d = skid_v;
    main_d   = in_data;
    case (state)
      SKID_EMPTY: begin
        if (push) begin
          main_ld  = 1'b1;
          main_v_d = 1'b1;
        end
      end
      SKID_ONE: begin
        if (push && pop) begin
          main_ld = 1'b1;
        end else if (push) begin
          skid_ld  = 1'b1;
          skid_v_d = 1'b1;
        end else if (pop) begin
          main_v_d = 1'b0;
        end
      end
      SKID_FULL: begin
        // in_ready is low here, so only a pop can happen; the older
        // skid entry moves up into the main register.
        if (pop) begin
          main_ld  = 1'b1;
          main_d   = skid_q;
          skid_v_d = 1'b0;
        end
      end
      default: begin
        // {skid_v, main_v} = 10 is unreachable; hold.
      end
    endcase
    // A flush cycle drops its handshakes; payload registers keep their
    // contents so they do not toggle needlessly.
    if (flush) begin
      main_ld = 1'b0;
      skid_ld = 1'b0;
    end
  end

  // Storage registers
  rvdffe_sync #(.WIDTH(1)) u_main_v (
    .clk (clk),
    .clr (rst | flush),
    .en  (1'b1),
    .d   (main_v_d),
    .q   (main_v)
  );

  rvdffe_sync #(.WIDTH(1)) u_skid_v (
    .clk (clk),
    .clr (rst | flush),
    .en  (1'b1),
    .d   (skid_v_d),
    .q   (skid_v)
  );

  rvdffe_sync #(.WIDTH(WIDTH)) u_main_q (
    .clk (clk),
    .clr (rst),
    .en  (main_ld),
    .d   (main_d),
    .q   (main_q)
  );

  rvdffe_sync #(.WIDTH(WIDTH)) u_skid_q (
    .clk (clk),
    .clr (rst),
    .en  (skid_ld),
    .d   (in_data),
    .q   (skid_q)
  );

endmodule

// File: doc/rvskid_buf.md
Name: rvskid_buf

Overview:
- Two-entry elastic (skid) pipeline stage that feeds a plain data register stage.
- Breaks the combinational ready path between producer and consumer without losing throughput.
- Holds WIDTH-bit payloads, 7 bits by default, matching the narrow field registers in the core datapath.
- Preserves order, sustains one transfer per cycle, and has a synchronous flush for pipeline kill.

Parameters:
WIDTH, 7, payload width in bits (legal range 1..64)

Ports:
clk  input  1  core clock; all state updates on its rising edge
rst  input  1  synchronous, active-high reset
flush  input  1  synchronous kill of all held entries
in_valid  input  1  producer offers in_data this cycle
in_ready  output  1  buffer can accept this cycle; driven from flops only
in_data  input  WIDTH  producer payload
out_valid  output  1  out_data holds a valid entry
out_ready  input  1  consumer accepts out_data this cycle
out_data  output  WIDTH  head-entry payload; driven directly from the main register
count  output  2  occupancy: 0, 1 or 2

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Storage: main register (main_q, main_v) drives the outputs; skid register (skid_q, skid_v) holds overflow. out_data = main_q, out_valid = main_v.
- States, encoded by {skid_v, main_v}:
  - EMPTY: 00
  - ONE: 01
  - FULL: 11
  - 10 is illegal; the bench asserts it never occurs.
- in_ready = ~skid_v. No combinational path from out_ready or in_valid to in_ready.
- Handshakes:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - Data must not be sampled when valid is low. in_data is don't-care when in_valid = 0.
- Transitions, each taking effect on the next edge:
  - EMPTY, push -> ONE; main_q <= in_data.
  - ONE, push & pop -> ONE; main_q <= in_data.
  - ONE, push & ~pop -> FULL; skid_q <= in_data.
  - ONE, ~push & pop -> EMPTY.
  - FULL, pop -> ONE; main_q <= skid_q. No push is possible because in_ready = 0.
  - Otherwise hold.
- Latency: one cycle from push to out_valid when empty. Two cycles when the entry lands in skid. Zero bubbles under continuous in_valid with out_ready.
- Ordering: strict FIFO. The skid entry is always older than any subsequent push.
- Flush:
  - Next edge forces EMPTY.
  - A push or pop in the flush cycle is discarded/ignored. The consumer may still see out_valid that cycle, but its state is dropped.
  - Flush has priority over all transitions. rst has priority over flush.
- Reset:
  - Every state bit and data register is cleared, so out_valid = 0, out_data = 0, in_ready = 1, count = 0 after the reset edge.
  - Handshakes in a cycle with rst = 1 are discarded.
  - Reset mid-operation drops all held data.
- count = main_v + skid_v.
- Data registers load only on the transitions above. Payload bits do not toggle otherwise, which saves power.
- Unknown-propagation: in_data X while in_valid = 0 must never reach out_data.

Decomposition:
- Shared package rv_pipe_pkg:
  - state encoding constants SKID_EMPTY = 2'b00, SKID_ONE = 2'b01, SKID_FULL = 2'b11;
  - localparam for the count width (2).
- One natural sub-module: rvdffe_sync, an enabled WIDTH-bit register with synchronous active-high clear. It is instantiated twice for main and skid data, with 1-bit instances for valid flags.

Test Plan:
1. Reset: hold rst = 1 for 2 cycles with in_valid = 1, in_data = 7'h55 -> after release, out_valid = 0, out_data = 7'h00, in_ready = 1, count = 0.
2. Streaming: push 7'h01..7'h10 on consecutive cycles with out_ready = 1 -> out_data sequence 7'h01..7'h10 beginning 1 cycle after the first push, no bubbles, count stays 1.
3. Backpressure: out_ready = 0, push 7'h0A then 7'h0B -> count = 2, in_ready = 0, 7'h0C held off. Raise out_ready -> outputs 7'h0A, 7'h0B, 7'h0C in order.
4. Flush: in FULL holding 7'h21 and 7'h22, assert flush with in_valid = 1, in_data = 7'h23 -> next cycle out_valid = 0, count = 0, in_ready = 1. 7'h23 never appears.
5. Mid-operation reset: FULL state, assert rst for 1 cycle concurrently with out_ready = 1 -> next cycle all outputs at reset values. Subsequent push of 7'h7F emerges alone.
6. Random: 10k cycles of random in_valid, out_ready and flush at 2% -> scoreboard order match, state 10 never reached, in_ready never depends combinationally on out_ready.
